regfile_scoreboard: RTL and testbench

//  Parametrised 2-read/1-write register file for the pipelined MIPS datapath; successor to the fixed 8x16 register_file.

---
 rtl/regfile_scoreboard_if.sv | 38 +++
 rtl/regfile_scoreboard.sv | 97 +++++++++
 tb/tb_regfile_scoreboard.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// Register file / scoreboard bus.
// Groups the writeback, decode-read and issue signals of regfile_scoreboard.
//   master: decode/writeback side. It drives the write, read-address and issue
//           fields and receives the read data, hazard flags and pending count.
//   slave : the register file itself.
interface regfile_scoreboard_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
);
  logic              reg_write_en;
  logic [ADDR_W-1:0] reg_write_dest;
  logic [DATA_W-1:0] reg_write_data;
  logic [ADDR_W-1:0] reg_read_addr_1;
  logic [DATA_W-1:0] reg_read_data_1;
  logic [ADDR_W-1:0] reg_read_addr_2;
  logic [DATA_W-1:0] reg_read_data_2;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_dest;
  logic              hazard_1;
  logic              hazard_2;
  logic [ADDR_W:0]   pending_cnt;

  modport master (
    output reg_write_en, reg_write_dest, reg_write_data,
    output reg_read_addr_1, reg_read_addr_2,
    output issue_en, issue_dest,
    input  reg_read_data_1, reg_read_data_2,
    input  hazard_1, hazard_2, pending_cnt
  );

  modport slave (
    input  reg_write_en, reg_write_dest, reg_write_data,
    input  reg_read_addr_1, reg_read_addr_2,
    input  issue_en, issue_dest,
    output reg_read_data_1, reg_read_data_2,
    output hazard_1, hazard_2, pending_cnt
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file for the pipelined MIPS datapath.
// It has two read ports and one write port. It adds an optional hardwired-zero
// register r0, write-to-read bypass, and a per-register pending scoreboard that
// drives the hazard flags for the stall logic.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset. It clears the storage and the pending bits.
//   bus  slave modport of regfile_scoreboard_if:
//        - write: reg_write_en, reg_write_dest, reg_write_data
//        - reads: reg_read_addr_1/2 in; reg_read_data_1/2 out, with zero latency
//        - issue: issue_en, issue_dest
//        - hazard_1/2: combinational
//        - pending_cnt: popcount of the pending bits
module regfile_scoreboard #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input logic                  clk,
  input logic                  rst,
  regfile_scoreboard_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pending_q;
  logic [DEPTH-1:0]  pending_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  logic write_ok;
  logic issue_ok;
  logic byp_1;
  logic byp_2;

  // A write or issue to r0 is dropped when r0 is hardwired to zero.
  always_comb begin
    write_ok = bus.reg_write_en;
    issue_ok = bus.issue_en;
    if (ZERO_REG != 0 && bus.reg_write_dest == '0) write_ok = 1'b0;
    if (ZERO_REG != 0 && bus.issue_dest == '0)     issue_ok = 1'b0;
  end

  // Next pending state. The issue is applied after the writeback clear, so a
  // new producer supersedes the writeback to the same register.
  always_comb begin
    pending_d = pending_q;
    if (bus.reg_write_en) pending_d[bus.reg_write_dest] = 1'b0;
    if (issue_ok)         pending_d[bus.issue_dest]     = 1'b1;
    cnt_d = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      cnt_d = cnt_d + CNT_W'(pending_d[i]);
    end
  end

  // Storage, pending bits and the registered pending count.
  // cnt_q always equals popcount(pending_q).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q     <= '{default: '0};
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      if (write_ok) mem_q[bus.reg_write_dest] <= bus.reg_write_data;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  // Same-cycle writeback matches on each read port.
  always_comb begin
    byp_1 = (BYPASS != 0) && bus.reg_write_en && (bus.reg_write_dest == bus.reg_read_addr_1);
    byp_2 = (BYPASS != 0) && bus.reg_write_en && (bus.reg_write_dest == bus.reg_read_addr_2);
  end

  // Read ports. The hardwired zero takes priority over bypass, and bypass over storage.
  always_comb begin
    bus.reg_read_data_1 = mem_q[bus.reg_read_addr_1];
    bus.reg_read_data_2 = mem_q[bus.reg_read_addr_2];
    if (byp_1) bus.reg_read_data_1 = bus.reg_write_data;
    if (byp_2) bus.reg_read_data_2 = bus.reg_write_data;
    if (ZERO_REG != 0 && bus.reg_read_addr_1 == '0) bus.reg_read_data_1 = '0;
    if (ZERO_REG != 0 && bus.reg_read_addr_2 == '0) bus.reg_read_data_2 = '0;
  end

  // Hazard: the source is pending and cannot be forwarded in this cycle.
  always_comb begin
    bus.hazard_1 = pending_q[bus.reg_read_addr_1] & ~byp_1;
    bus.hazard_2 = pending_q[bus.reg_read_addr_2] & ~byp_2;
  end

  assign bus.pending_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard.
// u_dut uses ZERO_REG=1 and BYPASS=1. u_dut_nb uses ZERO_REG=1 and BYPASS=0
// and mirrors the same stimulus.
module tb_regfile_scoreboard;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  regfile_scoreboard_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
  regfile_scoreboard_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_nb ();

  regfile_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1), .BYPASS(1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  regfile_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1), .BYPASS(0)) u_dut_nb (
    .clk (clk),
    .rst (rst),
    .bus (bus_nb.slave)
  );

  // The non-bypass instance sees exactly the same inputs.
  assign bus_nb.reg_write_en    = bus.reg_write_en;
  assign bus_nb.reg_write_dest  = bus.reg_write_dest;
  assign bus_nb.reg_write_data  = bus.reg_write_data;
  assign bus_nb.reg_read_addr_1 = bus.reg_read_addr_1;
  assign bus_nb.reg_read_addr_2 = bus.reg_read_addr_2;
  assign bus_nb.issue_en        = bus.issue_en;
  assign bus_nb.issue_dest      = bus.issue_dest;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst                 = 1'b1;
    bus.reg_write_en    = 1'b0;
    bus.reg_write_dest  = '0;
    bus.reg_write_data  = '0;
    bus.reg_read_addr_1 = 4'd3;
    bus.reg_read_addr_2 = 4'd5;
    bus.issue_en        = 1'b0;
    bus.issue_dest      = '0;

    // Reset state
    #2;
    check("rst_rd1", 32'(bus.reg_read_data_1), 32'h0);
    check("rst_rd2", 32'(bus.reg_read_data_2), 32'h0);
    check("rst_hz1", 32'(bus.hazard_1), 32'h0);
    check("rst_cnt", 32'(bus.pending_cnt), 32'h0);
    #1 rst = 1'b0;

    // Write r3=0x07, then read it on both ports; r4 reads 0
    @(negedge clk);
    bus.reg_write_en = 1'b1; bus.reg_write_dest = 4'd3; bus.reg_write_data = 8'h07;
    @(posedge clk); #1;
    bus.reg_write_en = 1'b0;
    bus.reg_read_addr_1 = 4'd3; bus.reg_read_addr_2 = 4'd3;
    #1;
    check("wr3_rd1", 32'(bus.reg_read_data_1), 32'h07);
    check("wr3_rd2", 32'(bus.reg_read_data_2), 32'h07);
    bus.reg_read_addr_2 = 4'd4;
    #1;
    check("rd4_zero", 32'(bus.reg_read_data_2), 32'h00);

    // Write r5=0x11 and issue r7 in the same cycle
    @(negedge clk);
    bus.reg_write_en = 1'b1; bus.reg_write_dest = 4'd5; bus.reg_write_data = 8'h11;
    bus.issue_en = 1'b1; bus.issue_dest = 4'd7;
    @(posedge clk); #1;
    bus.reg_write_en = 1'b0; bus.issue_en = 1'b0;
    bus.reg_read_addr_1 = 4'd5; bus.reg_read_addr_2 = 4'd7;
    #1;
    check("wr5_rd1", 32'(bus.reg_read_data_1), 32'h11);
    check("iss7_hz2", 32'(bus.hazard_2), 32'h1);
    check("iss7_cnt", 32'(bus.pending_cnt), 32'h1);

    // Mid-cycle reset pulse: state clears without a clock edge
    bus.reg_read_addr_2 = 4'd3;
    rst = 1'b1;
    #1;
    check("mrst_rd1", 32'(bus.reg_read_data_1), 32'h0);
    check("mrst_rd2", 32'(bus.reg_read_data_2), 32'h0);
    check("mrst_cnt", 32'(bus.pending_cnt), 32'h0);
    bus.reg_read_addr_1 = 4'd7;
    #1;
    check("mrst_hz1", 32'(bus.hazard_1), 32'h0);
    rst = 1'b0;

    // Write r9=0xA5 while reading addr 9
    @(negedge clk);
    bus.reg_write_en = 1'b1; bus.reg_write_dest = 4'd9; bus.reg_write_data = 8'hA5;
    bus.reg_read_addr_1 = 4'd9;
    #1;
    check("byp_rd1", 32'(bus.reg_read_data_1), 32'hA5);
    check("nobyp_rd1_old", 32'(bus_nb.reg_read_data_1), 32'h00);
    @(posedge clk); #1;
    bus.reg_write_en = 1'b0;
    #1;
    check("byp_rd1_after", 32'(bus.reg_read_data_1), 32'hA5);
    check("nobyp_rd1_after", 32'(bus_nb.reg_read_data_1), 32'hA5);

    // r0 is hardwired: a write of 0xFF and an issue to r0 are both ignored
    @(negedge clk);
    bus.reg_write_en = 1'b1; bus.reg_write_dest = 4'd0; bus.reg_write_data = 8'hFF;
    bus.issue_en = 1'b1; bus.issue_dest = 4'd0;
    bus.reg_read_addr_1 = 4'd0;
    #1;
    check("z0_rd1_same", 32'(bus.reg_read_data_1), 32'h00);
    @(posedge clk); #1;
    bus.reg_write_en = 1'b0; bus.issue_en = 1'b0;
    #1;
    check("z0_rd1", 32'(bus.reg_read_data_1), 32'h00);
    check("z0_hz1", 32'(bus.hazard_1), 32'h0);
    check("z0_cnt", 32'(bus.pending_cnt), 32'h0);

    // Issue r6, then write back r6=0x3C
    @(negedge clk);
    bus.issue_en = 1'b1; bus.issue_dest = 4'd6;
    @(posedge clk); #1;
    bus.issue_en = 1'b0;
    bus.reg_read_addr_1 = 4'd6;
    #1;
    check("iss6_hz1", 32'(bus.hazard_1), 32'h1);
    check("iss6_cnt", 32'(bus.pending_cnt), 32'h1);
    bus.reg_write_en = 1'b1; bus.reg_write_dest = 4'd6; bus.reg_write_data = 8'h3C;
    #1;
    check("wb6_hz1", 32'(bus.hazard_1), 32'h0);
    check("wb6_rd1", 32'(bus.reg_read_data_1), 32'h3C);
    check("wb6_nb_hz1", 32'(bus_nb.hazard_1), 32'h1);
    check("wb6_nb_rd1", 32'(bus_nb.reg_read_data_1), 32'h00);
    @(posedge clk); #1;
    bus.reg_write_en = 1'b0;
    #1;
    check("wb6_cnt", 32'(bus.pending_cnt), 32'h0);
    check("wb6_hz1_after", 32'(bus.hazard_1), 32'h0);
    check("wb6_rd1_after", 32'(bus.reg_read_data_1), 32'h3C);

    // Issue and writeback of r6 in the same cycle: the issue wins
    @(negedge clk);
    bus.issue_en = 1'b1; bus.issue_dest = 4'd6;
    bus.reg_write_en = 1'b1; bus.reg_write_dest = 4'd6; bus.reg_write_data = 8'h5A;
    @(posedge clk); #1;
    bus.issue_en = 1'b0; bus.reg_write_en = 1'b0;
    #1;
    check("setwin_hz1", 32'(bus.hazard_1), 32'h1);
    check("setwin_cnt", 32'(bus.pending_cnt), 32'h1);
    check("setwin_rd1", 32'(bus.reg_read_data_1), 32'h5A);

    // Issue all 15 non-zero registers
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      bus.issue_en = 1'b1; bus.issue_dest = 4'(i);
    end
    @(posedge clk); #1;
    bus.issue_en = 1'b0;
    bus.reg_read_addr_2 = 4'd12;
    #1;
    check("all_cnt", 32'(bus.pending_cnt), 32'd15);
    check("all_hz2", 32'(bus.hazard_2), 32'h1);
    bus.reg_read_addr_2 = 4'd0;
    #1;
    check("all_hz2_r0", 32'(bus.hazard_2), 32'h0);

    // A further issue to r0 does not change the count
    @(negedge clk);
    bus.issue_en = 1'b1; bus.issue_dest = 4'd0;
    @(posedge clk); #1;
    bus.issue_en = 1'b0;
    #1;
    check("all_r0_cnt", 32'(bus.pending_cnt), 32'd15);

    // Writeback of r12 clears one bit; both ports read r12 independently
    @(negedge clk);
    bus.reg_write_en = 1'b1; bus.reg_write_dest = 4'd12; bus.reg_write_data = 8'hC3;
    bus.reg_read_addr_1 = 4'd12; bus.reg_read_addr_2 = 4'd12;
    @(posedge clk); #1;
    bus.reg_write_en = 1'b0;
    #1;
    check("wb12_cnt", 32'(bus.pending_cnt), 32'd14);
    check("wb12_hz1", 32'(bus.hazard_1), 32'h0);
    check("wb12_hz2", 32'(bus.hazard_2), 32'h0);
    check("wb12_rd2", 32'(bus.reg_read_data_2), 32'hC3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
